// File: rtl/dram_line_cache.sv
`default_nettype none
// ============================================================================
// Module      : dram_line_cache
// Description : Write-back, write-allocate, direct-mapped cache of 8 one-word
//               lines placed in front of the DRAM bridge. Hits are served
//               locally; misses issue single-word bridge transactions (victim
//               write-back first when dirty, then a fill for reads). A flush
//               command drains every dirty line to DRAM in index order.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/req_wr/req_addr/req_wdata : core request (sampled when req_ready)
//   req_ready         : high in IDLE while flush is low
//   rsp_valid/rsp_rdata : one-cycle completion pulse, read data (0 for writes)
//   flush/flush_done  : flush request level / one-cycle completion pulse
//   C_in_valid/C_r_wb/C_addr/C_data_w : bridge request (1 = read on C_r_wb)
//   C_out_valid/C_data_r              : bridge completion and read data
// ============================================================================
module dram_line_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        flush,
  output logic        flush_done,
  output logic        C_in_valid,
  output logic        C_r_wb,
  output logic [7:0]  C_addr,
  output logic [31:0] C_data_w,
  input  logic        C_out_valid,
  input  logic [31:0] C_data_r
);

  localparam int         LINES      = 8;
  localparam logic       MODE_READ  = 1'b1;
  localparam logic [2:0] c_last_idx = 3'(LINES - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOOKUP     = 4'd1,
    S_WB_ISSUE   = 4'd2,
    S_WB_WAIT    = 4'd3,
    S_FILL_ISSUE = 4'd4,
    S_FILL_WAIT  = 4'd5,
    S_RESP       = 4'd6,
    S_FL_SCAN    = 4'd7,
    S_FL_ISSUE   = 4'd8,
    S_FL_WAIT    = 4'd9,
    S_FL_DONE    = 4'd10
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Registered request
  logic        r_wr;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;

  // Flush scan index
  logic [2:0]  r_fidx;

  // Line storage
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [4:0]       r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic [2:0]  w_idx;
  logic [4:0]  w_tag;
  logic        w_hit;
  logic [2:0]  w_wb_idx;

  assign w_idx = r_addr[2:0];
  assign w_tag = r_addr[7:3];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // The write-back encoding is shared between eviction and flush; only the
  // source of the line index differs.
  assign w_wb_idx = (r_state == S_FL_ISSUE) ? r_fidx : w_idx;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'h0;
    flush_done = 1'b0;
    C_in_valid = 1'b0;
    C_r_wb     = 1'b0;
    C_addr     = 8'h0;
    C_data_w   = 32'h0;

    case (r_state)
      S_IDLE: begin
        req_ready = !flush;
        if (flush) begin
          w_next = S_FL_SCAN;
        end else if (req_valid) begin
          w_next = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (w_hit) begin
          w_next = S_RESP;
        end else if (r_dirty[w_idx]) begin
          w_next = S_WB_ISSUE;
        end else if (!r_wr) begin
          w_next = S_FILL_ISSUE;
        end else begin
          // A line is a single word, so a write miss never needs a fill.
          w_next = S_RESP;
        end
      end

      S_WB_ISSUE, S_FL_ISSUE: begin
        C_in_valid = 1'b1;
        C_r_wb     = ~MODE_READ;
        C_addr     = {r_tag[w_wb_idx], w_wb_idx};
        C_data_w   = r_data[w_wb_idx];
        w_next     = (r_state == S_WB_ISSUE) ? S_WB_WAIT : S_FL_WAIT;
      end

      S_WB_WAIT: begin
        if (C_out_valid) begin
          w_next = r_wr ? S_RESP : S_FILL_ISSUE;
        end
      end

      S_FILL_ISSUE: begin
        C_in_valid = 1'b1;
        C_r_wb     = MODE_READ;
        C_addr     = r_addr;
        w_next     = S_FILL_WAIT;
      end

      S_FILL_WAIT: begin
        if (C_out_valid) begin
          w_next = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_wr ? 32'h0 : r_data[w_idx];
        w_next    = S_IDLE;
      end

      S_FL_SCAN: begin
        if (r_dirty[r_fidx]) begin
          w_next = S_FL_ISSUE;
        end else if (r_fidx == c_last_idx) begin
          w_next = S_FL_DONE;
        end
      end

      S_FL_WAIT: begin
        if (C_out_valid) begin
          w_next = (r_fidx == c_last_idx) ? S_FL_DONE : S_FL_SCAN;
        end
      end

      S_FL_DONE: begin
        flush_done = 1'b1;
        w_next     = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture, flush index and line status bits
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_addr  <= 8'h0;
      r_wdata <= 32'h0;
      r_fidx  <= 3'd0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_fidx <= 3'd0;
          end else if (req_valid) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
          end
        end

        S_WB_WAIT: begin
          if (C_out_valid) begin
            r_dirty[w_idx] <= 1'b0;
          end
        end

        S_FILL_WAIT: begin
          if (C_out_valid) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end

        S_RESP: begin
          if (r_wr) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b1;
          end
        end

        S_FL_SCAN: begin
          if (!r_dirty[r_fidx] && (r_fidx != c_last_idx)) begin
            r_fidx <= r_fidx + 3'd1;
          end
        end

        S_FL_WAIT: begin
          if (C_out_valid) begin
            r_dirty[r_fidx] <= 1'b0;
            if (r_fidx != c_last_idx) begin
              r_fidx <= r_fidx + 3'd1;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Tag and data arrays (not reset; qualified by r_valid)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((r_state == S_FILL_WAIT) && C_out_valid) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= C_data_r;
    end else if ((r_state == S_RESP) && r_wr) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_line_cache.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dram_line_cache
// Description : Self-checking bench for dram_line_cache. A DRAM bridge model
//               answers requests after a random latency; a flat memory image
//               holds the architecturally correct value of every address and
//               a per-index line table predicts hits and victim write-backs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_line_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [7:0]  req_addr = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [31:0] C_data_w;
  logic        C_out_valid = 1'b0;
  logic [31:0] C_data_r = 32'h0;

  dram_line_cache dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .flush       (flush),
    .flush_done  (flush_done),
    .C_in_valid  (C_in_valid),
    .C_r_wb      (C_r_wb),
    .C_addr      (C_addr),
    .C_data_w    (C_data_w),
    .C_out_valid (C_out_valid),
    .C_data_r    (C_data_r)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          in_cyc;
    int          out_cyc;
  } txn_t;
  txn_t log_q[$];

  logic [31:0] dram    [256];   // bridge backing store
  logic [31:0] ref_val [256];   // architecturally visible value per address
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [4:0]  m_tag   [8];

  bit hold = 1'b0;              // bridge withholds completions while set
  bit pend = 1'b0;
  int cnt  = 0;
  int pidx = 0;

  // --------------------------------------------------------------------------
  // Bridge model and always-on output hygiene checks (all at negedge)
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      C_out_valid = 1'b0;
      C_data_r    = $urandom;
      if (cyc > 0) begin
        checks++;
        if ((!C_in_valid && (C_r_wb !== 1'b0 || C_addr !== 8'h0 || C_data_w !== 32'h0)) ||
            (C_in_valid && C_r_wb && C_data_w !== 32'h0) ||
            (!rsp_valid && rsp_rdata !== 32'h0)) begin
          failures++;
          $display("FAIL idle_outputs cyc=%0d in_valid=%b r_wb=%b addr=%h data_w=%h rsp_valid=%b rdata=%h (required 0 when not valid)",
                   cyc, C_in_valid, C_r_wb, C_addr, C_data_w, rsp_valid, rsp_rdata);
        end
      end
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend && !hold) begin
          cnt--;
          if (cnt == 0) begin
            C_out_valid = 1'b1;
            if (log_q[pidx].wr) dram[log_q[pidx].addr] = log_q[pidx].data;
            else                C_data_r = dram[log_q[pidx].addr];
            log_q[pidx].out_cyc = cyc;
            pend = 1'b0;
          end
        end
        if (C_in_valid === 1'b1) begin
          checks++;
          if (pend) begin
            failures++;
            $display("FAIL one_outstanding cyc=%0d new request while previous one pending (required none)", cyc);
          end
          log_q.push_back('{wr: (C_r_wb == 1'b0), addr: C_addr, data: C_data_w, in_cyc: cyc, out_cyc: -1});
          pidx = log_q.size() - 1;
          pend = 1'b1;
          cnt  = $urandom_range(1, 3);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    for (int a = 0; a < 256; a++) ref_val[a] = dram[a];   // dirty data is lost on reset
  endtask

  task automatic do_op(input bit wr, input logic [7:0] addr, input logic [31:0] wd);
    logic [2:0]  idx;
    logic [4:0]  tag;
    logic [7:0]  vaddr;
    bit          hit, vd, fill;
    int          exp_n, c0, n0, to, k, exp_rc;
    logic [31:0] exp_rd;
    idx   = addr[2:0];
    tag   = addr[7:3];
    hit   = m_valid[idx] && (m_tag[idx] == tag);
    vd    = !hit && m_dirty[idx];
    fill  = !hit && !wr;
    vaddr = {m_tag[idx], idx};
    exp_n = (vd ? 1 : 0) + (fill ? 1 : 0);
    exp_rd = wr ? 32'h0 : ref_val[addr];

    to = 0;
    while (req_ready !== 1'b1 && to < 100) begin @(negedge clk); to++; end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_timeout got=%b required=1", req_ready);
      return;
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    c0 = cyc; n0 = log_q.size();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    to = 0;
    while (rsp_valid !== 1'b1 && to < 200) begin @(negedge clk); to++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout addr=%h got rsp_valid=%b required=1", addr, rsp_valid);
      return;
    end

    checks++;
    if (rsp_rdata !== exp_rd) begin
      failures++;
      $display("FAIL rsp_rdata addr=%h wr=%b got=%h required=%h", addr, wr, rsp_rdata, exp_rd);
    end
    checks++;
    if (log_q.size() - n0 != exp_n) begin
      failures++;
      $display("FAIL bridge_txn_count addr=%h wr=%b got=%0d required=%0d", addr, wr, log_q.size() - n0, exp_n);
    end else begin
      k = n0;
      if (vd) begin
        checks++;
        if (!log_q[k].wr || log_q[k].addr !== vaddr || log_q[k].data !== ref_val[vaddr] || log_q[k].in_cyc != c0 + 2) begin
          failures++;
          $display("FAIL victim_wb got wr=%b addr=%h data=%h cyc=%0d required wr=1 addr=%h data=%h cyc=%0d",
                   log_q[k].wr, log_q[k].addr, log_q[k].data, log_q[k].in_cyc, vaddr, ref_val[vaddr], c0 + 2);
        end
        k++;
      end
      if (fill) begin
        checks++;
        if (log_q[k].wr || log_q[k].addr !== addr ||
            log_q[k].in_cyc != (vd ? log_q[k-1].out_cyc + 1 : c0 + 2)) begin
          failures++;
          $display("FAIL fill_req got wr=%b addr=%h cyc=%0d required wr=0 addr=%h cyc=%0d",
                   log_q[k].wr, log_q[k].addr, log_q[k].in_cyc, addr, vd ? log_q[k-1].out_cyc + 1 : c0 + 2);
        end
      end
      exp_rc = (exp_n == 0) ? c0 + 2 : log_q[log_q.size()-1].out_cyc + 1;
      checks++;
      if (cyc != exp_rc) begin
        failures++;
        $display("FAIL rsp_latency addr=%h got cycle=%0d required cycle=%0d", addr, cyc - c0, exp_rc - c0);
      end
    end

    if (hit) begin
      if (wr) m_dirty[idx] = 1'b1;
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = wr;
    end
    if (wr) ref_val[addr] = wd;
  endtask

  task automatic do_flush();
    logic [7:0] exp_a[$];
    int c0, n0, to, exp_done;
    for (int i = 0; i < 8; i++) if (m_dirty[i]) exp_a.push_back({m_tag[i], 3'(i)});
    to = 0;
    while (req_ready !== 1'b1 && to < 100) begin @(negedge clk); to++; end
    flush = 1'b1;
    c0 = cyc; n0 = log_q.size();
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    to = 0;
    while (flush_done !== 1'b1 && to < 300) begin @(negedge clk); to++; end
    checks++;
    if (flush_done !== 1'b1) begin
      failures++;
      $display("FAIL flush_done_timeout got=%b required=1", flush_done);
      return;
    end
    checks++;
    if (log_q.size() - n0 != exp_a.size()) begin
      failures++;
      $display("FAIL flush_wb_count got=%0d required=%0d", log_q.size() - n0, exp_a.size());
    end else begin
      exp_done = c0 + 9;
      for (int j = 0; j < exp_a.size(); j++) begin
        checks++;
        if (!log_q[n0+j].wr || log_q[n0+j].addr !== exp_a[j] || log_q[n0+j].data !== ref_val[exp_a[j]]) begin
          failures++;
          $display("FAIL flush_wb[%0d] got wr=%b addr=%h data=%h required wr=1 addr=%h data=%h",
                   j, log_q[n0+j].wr, log_q[n0+j].addr, log_q[n0+j].data, exp_a[j], ref_val[exp_a[j]]);
        end
        exp_done += 1 + log_q[n0+j].out_cyc - log_q[n0+j].in_cyc;
      end
      checks++;
      if (cyc != exp_done) begin
        failures++;
        $display("FAIL flush_latency got=%0d required=%0d", cyc - c0, exp_done - c0);
      end
    end
    @(negedge clk);
    checks++;
    if (flush_done !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_return got flush_done=%b req_ready=%b required 0/1", flush_done, req_ready);
    end
    for (int i = 0; i < 8; i++) m_dirty[i] = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || flush_done !== 1'b0 || C_in_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b rsp=%b done=%b in_valid=%b required 1/0/0/0",
               req_ready, rsp_valid, flush_done, C_in_valid);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || flush_done !== 1'b0 || C_in_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_outputs got ready=%b rsp=%b done=%b in_valid=%b required 1/0/0/0",
               req_ready, rsp_valid, flush_done, C_in_valid);
    end
  endtask

  task automatic test_read_miss_hit();
    do_reset();
    dram[8'h15] = 32'hDEADBEEF; ref_val[8'h15] = 32'hDEADBEEF;
    do_op(1'b0, 8'h15, 32'h0);
    do_op(1'b0, 8'h15, 32'h0);
  endtask

  task automatic test_write_alloc();
    do_op(1'b1, 8'h0A, 32'h12345678);
    do_op(1'b0, 8'h0A, 32'h0);
  endtask

  task automatic test_dirty_evict();
    do_op(1'b1, 8'h0A, 32'h00000011);
    do_op(1'b0, 8'h12, 32'h0);
  endtask

  task automatic test_flush();
    do_reset();
    do_op(1'b1, 8'h09, 32'hA5A50001);
    do_op(1'b1, 8'h0E, 32'hA5A50006);
    do_op(1'b0, 8'h03, 32'h0);
    do_flush();
    do_flush();
  endtask

  task automatic test_flush_req_collision();
    int c0, to, rsp_seen, n0;
    do_reset();
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h33; req_wdata = 32'h0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL collision_ready got=%b required=0", req_ready);
    end
    c0 = cyc; n0 = log_q.size();
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    to = 0; rsp_seen = 0;
    while (flush_done !== 1'b1 && to < 100) begin
      if (rsp_valid === 1'b1) rsp_seen++;
      @(negedge clk); to++;
    end
    checks++;
    if (flush_done !== 1'b1 || cyc != c0 + 9 || rsp_seen != 0) begin
      failures++;
      $display("FAIL collision_flush got done=%b latency=%0d early_rsp=%0d required 1/9/0",
               flush_done, cyc - c0, rsp_seen);
    end
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    to = 0;
    while (rsp_valid !== 1'b1 && to < 100) begin @(negedge clk); to++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== ref_val[8'h33] || log_q.size() - n0 != 1) begin
      failures++;
      $display("FAIL collision_req got rsp=%b rdata=%h txns=%0d required 1/%h/1",
               rsp_valid, rsp_rdata, log_q.size() - n0, ref_val[8'h33]);
    end
    m_valid[3] = 1'b1; m_tag[3] = 5'h06; m_dirty[3] = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    int to, n0;
    do_reset();
    hold = 1'b1;
    n0 = log_q.size();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h15;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    to = 0;
    while (log_q.size() == n0 && to < 20) begin @(negedge clk); to++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || flush_done !== 1'b0 || C_in_valid !== 1'b0 ||
        C_r_wb !== 1'b0 || C_addr !== 8'h0 || C_data_w !== 32'h0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_fill_reset got rsp=%b done=%b in_valid=%b r_wb=%b addr=%h ready=%b required 0/0/0/0/00/1",
               rsp_valid, flush_done, C_in_valid, C_r_wb, C_addr, req_ready);
    end
    rst = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    for (int a = 0; a < 256; a++) ref_val[a] = dram[a];
    do_op(1'b0, 8'h15, 32'h0);
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_flush();
      end else begin
        a = {5'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
        do_op(1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    do_flush();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      dram[a]    = $urandom;
      ref_val[a] = dram[a];
    end
    test_reset();
    test_read_miss_hit();
    test_write_alloc();
    test_dirty_evict();
    test_flush();
    test_flush_req_collision();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
